stacker: RTL and testbench

Packs a stream of 16-bit audio samples into 128-bit phrases for the wide memory/FIFO path that feeds the unstacker. It is the write-side counterpart of the unstacker. Words are placed lowest-slot-first, so a phrase produced here unstacks into the original sample order. A sample carrying tlast closes the phrase early; the remaining slots are padded and the phrase leaves with tlast set.

---
 rtl/audio_pkg.sv | 9 +
 rtl/stacker_if.sv | 36 +++
 rtl/stacker.sv | 112 +++++++++++
 tb/tb_stacker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: constants shared by the stacker and the unstacker.
// A phrase is WORDS_PER_PHRASE audio words packed lowest slot first, so
// slot k lives at bits [AUDIO_WORD_W*k +: AUDIO_WORD_W].
package audio_pkg;
  localparam int AUDIO_WORD_W     = 16;
  localparam int WORDS_PER_PHRASE = 8;
  localparam int PHRASE_W         = 128;
  localparam int OFFSET_W         = 3;
endpackage

// File: rtl/stacker_if.sv
// stacker_if: bundles the sample stream into the stacker, the phrase
// stream out of it, and the accepted-phrase counter.
//
// Handshake: on both streams a transfer happens on a rising clock edge where
// tvalid and tready are both 1. Once a source raises tvalid it holds tvalid,
// tdata and tlast stable until that transfer. tready may be raised or dropped
// at any time and never depends on the tvalid of the same stream.
//
// Modports:
//   master - sample producer / phrase consumer (drives audio_t*, chunk tready)
//   slave  - the stacker itself
interface stacker_if;
  import audio_pkg::*;

  logic                    audio_tvalid;
  logic                    audio_tready;
  logic [AUDIO_WORD_W-1:0] audio_tdata;
  logic                    audio_tlast;
  logic                    audio_chunk_tvalid;
  logic                    audio_chunk_tready;
  logic [PHRASE_W-1:0]     audio_chunk_tdata;
  logic                    audio_chunk_tlast;
  logic [31:0]             phrase_count;

  modport master (
    output audio_tvalid, audio_tdata, audio_tlast, audio_chunk_tready,
    input  audio_tready, audio_chunk_tvalid, audio_chunk_tdata,
           audio_chunk_tlast, phrase_count
  );

  modport slave (
    input  audio_tvalid, audio_tdata, audio_tlast, audio_chunk_tready,
    output audio_tready, audio_chunk_tvalid, audio_chunk_tdata,
           audio_chunk_tlast, phrase_count
  );
endinterface

// File: rtl/stacker.sv
// stacker: packs 16-bit audio samples into 128-bit phrases, lowest slot first.
// Eight samples, or any sample carrying tlast, close a phrase. Slots above the
// closing sample are filled with PAD_WORD and the phrase carries that tlast.
//
// Ports:
//   clk_in  - clock, all state on its rising edge
//   rst_in  - synchronous active-high reset
//   bus     - stacker_if.slave: sample input stream, phrase output stream,
//             phrase_count (phrases accepted downstream, wraps at 2^32)
//
// The phrase output is a single register. Input is stalled only while that
// register is full and downstream is not taking it, so audio_tready never
// looks at the incoming sample.
module stacker
  import audio_pkg::*;
#(
  parameter logic [AUDIO_WORD_W-1:0] PAD_WORD = 16'h0000
) (
  input  logic     clk_in,
  input  logic     rst_in,
  stacker_if.slave bus
);

  localparam logic [PHRASE_W-1:0] PAD_FILL = {WORDS_PER_PHRASE{PAD_WORD}};

  logic [PHRASE_W-1:0]         acc;
  logic [OFFSET_W-1:0]         offset;
  logic [PHRASE_W-1:0]         out_data;
  logic                        out_last;
  logic                        out_valid;
  logic [31:0]                 phrase_cnt;

  logic                        accept_in;
  logic                        accept_out;
  logic                        closing;
  logic [WORDS_PER_PHRASE-1:0] pad_slots;
  logic [PHRASE_W-1:0]         closed_phrase;

  // Slots strictly above the current write slot get padding on an early close.
  function automatic logic [WORDS_PER_PHRASE-1:0] pad_mask(
    input logic [OFFSET_W-1:0] off
  );
    logic [WORDS_PER_PHRASE-1:0] m;
    m = '0;
    for (int k = 0; k < WORDS_PER_PHRASE; k++) begin
      m[k] = (k > int'(off));
    end
    return m;
  endfunction

  assign bus.audio_tready = !rst_in && (!out_valid || bus.audio_chunk_tready);

  assign accept_in  = bus.audio_tvalid && bus.audio_tready;
  assign accept_out = out_valid && bus.audio_chunk_tready;
  assign closing    = (offset == OFFSET_W'(WORDS_PER_PHRASE - 1)) || bus.audio_tlast;

  // Phrase as it leaves on a closing sample: accumulated slots below the
  // offset, the incoming sample at the offset, padding above it.
  always_comb begin
    closed_phrase = '0;
    pad_slots     = pad_mask(offset);
    for (int k = 0; k < WORDS_PER_PHRASE; k++) begin
      if (pad_slots[k]) begin
        closed_phrase[k*AUDIO_WORD_W +: AUDIO_WORD_W] = PAD_WORD;
      end else if (k == int'(offset)) begin
        closed_phrase[k*AUDIO_WORD_W +: AUDIO_WORD_W] = bus.audio_tdata;
      end else begin
        closed_phrase[k*AUDIO_WORD_W +: AUDIO_WORD_W] =
          acc[k*AUDIO_WORD_W +: AUDIO_WORD_W];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc        <= PAD_FILL;
      offset     <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      phrase_cnt <= '0;
    end else begin
      if (accept_out) begin
        phrase_cnt <= phrase_cnt + 32'd1;
      end

      if (accept_in && closing) begin
        // A new phrase may load in the same cycle the old one leaves,
        // so out_valid stays high with no bubble.
        out_data  <= closed_phrase;
        out_last  <= bus.audio_tlast;
        out_valid <= 1'b1;
        acc       <= PAD_FILL;
        offset    <= '0;
      end else begin
        if (accept_in) begin
          acc[int'(offset)*AUDIO_WORD_W +: AUDIO_WORD_W] <= bus.audio_tdata;
          offset <= offset + OFFSET_W'(1);
        end
        if (accept_out) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.audio_chunk_tvalid = out_valid;
  assign bus.audio_chunk_tdata  = out_data;
  assign bus.audio_chunk_tlast  = out_last;
  assign bus.phrase_count       = phrase_cnt;

endmodule

// File: tb/tb_stacker.sv
// tb_stacker: directed-vector bench for stacker. Two instances: dut_a with
// PAD_WORD=0 and dut_b with PAD_WORD=16'hFFFF. Expected phrases are pushed
// into per-instance queues when stimulus is issued; monitors pop and compare
// on every accepted phrase.
module tb_stacker;
  import audio_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  stacker_if bus_a ();
  stacker_if bus_b ();

  stacker #(.PAD_WORD(16'h0000)) dut_a (.clk_in(clk_in), .rst_in(rst_in), .bus(bus_a));
  stacker #(.PAD_WORD(16'hFFFF)) dut_b (.clk_in(clk_in), .rst_in(rst_in), .bus(bus_b));

  // ---------------- scoreboard state ----------------
  logic [PHRASE_W-1:0] exp_q[$];
  logic                exp_last_q[$];
  logic [PHRASE_W-1:0] exp_pad_q[$];
  logic                exp_pad_last_q[$];
  int                  stamp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [PHRASE_W-1:0] act,
                     input logic [PHRASE_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic push_a(input logic [PHRASE_W-1:0] d, input logic l);
    exp_q.push_back(d);
    exp_last_q.push_back(l);
  endtask

  task automatic push_b(input logic [PHRASE_W-1:0] d, input logic l);
    exp_pad_q.push_back(d);
    exp_pad_last_q.push_back(l);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk_in) begin
    if (!rst_in && bus_a.audio_chunk_tvalid && bus_a.audio_chunk_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_phrase_a: actual=%0h required=none",
                 bus_a.audio_chunk_tdata);
      end else begin
        chk("phrase_a_data", bus_a.audio_chunk_tdata, exp_q.pop_front());
        chk("phrase_a_last", PHRASE_W'(bus_a.audio_chunk_tlast),
            PHRASE_W'(exp_last_q.pop_front()));
        stamp_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in && bus_b.audio_chunk_tvalid && bus_b.audio_chunk_tready) begin
      if (exp_pad_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_phrase_b: actual=%0h required=none",
                 bus_b.audio_chunk_tdata);
      end else begin
        chk("phrase_b_data", bus_b.audio_chunk_tdata, exp_pad_q.pop_front());
        chk("phrase_b_last", PHRASE_W'(bus_b.audio_chunk_tlast),
            PHRASE_W'(exp_pad_last_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one sample and holds it until accepted. stalls counts cycles
  // where tready was low; stamp is the cycle count just after the accept edge.
  task automatic send(input int which, input logic [15:0] d, input logic l,
                      output int stalls, output int stamp);
    int   waited;
    logic r;
    stalls = 0;
    waited = 0;
    r      = 1'b0;
    if (which == 0) begin
      bus_a.audio_tvalid = 1'b1; bus_a.audio_tdata = d; bus_a.audio_tlast = l;
    end else begin
      bus_b.audio_tvalid = 1'b1; bus_b.audio_tdata = d; bus_b.audio_tlast = l;
    end
    while (!r && waited < 100) begin
      @(negedge clk_in);
      r = (which == 0) ? bus_a.audio_tready : bus_b.audio_tready;
      if (!r) stalls++;
      @(posedge clk_in);
      waited++;
    end
    #1;
    if (which == 0) begin
      bus_a.audio_tvalid = 1'b0; bus_a.audio_tlast = 1'b0;
    end else begin
      bus_b.audio_tvalid = 1'b0; bus_b.audio_tlast = 1'b0;
    end
    stamp = cyc;
    if (!r) begin
      n_checks++;
      $display("FAIL send_timeout: actual=not_accepted required=accepted data=%0h", d);
    end
  endtask

  // Sends base+1 .. base+n, tlast on the final sample when last_end is set.
  task automatic send_seq(input int which, input logic [15:0] base, input int n,
                          input logic last_end, output int stalls,
                          output int last_stamp);
    int s, st;
    stalls     = 0;
    last_stamp = 0;
    for (int i = 1; i <= n; i++) begin
      send(which, base + 16'(i), last_end && (i == n), s, st);
      stalls     += s;
      last_stamp  = st;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || exp_pad_q.size() != 0) && w < 200) begin
      @(posedge clk_in);
      w++;
    end
    if (exp_q.size() != 0 || exp_pad_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: actual=%0d/%0d pending required=0",
               exp_q.size(), exp_pad_q.size());
    end
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int                  stalls, ls, w;
    logic [PHRASE_W-1:0] ph;
    logic [PHRASE_W-1:0] held;

    bus_a.audio_tvalid = 1'b0; bus_a.audio_tdata = '0; bus_a.audio_tlast = 1'b0;
    bus_a.audio_chunk_tready = 1'b1;
    bus_b.audio_tvalid = 1'b0; bus_b.audio_tdata = '0; bus_b.audio_tlast = 1'b0;
    bus_b.audio_chunk_tready = 1'b1;

    // Reset state
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("tready_in_reset_a", PHRASE_W'(bus_a.audio_tready), '0);
    chk("tready_in_reset_b", PHRASE_W'(bus_b.audio_tready), '0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("tready_after_reset", PHRASE_W'(bus_a.audio_tready), PHRASE_W'(1));
    chk("tvalid_after_reset", PHRASE_W'(bus_a.audio_chunk_tvalid), '0);
    chk("tdata_after_reset",  bus_a.audio_chunk_tdata, '0);
    chk("tlast_after_reset",  PHRASE_W'(bus_a.audio_chunk_tlast), '0);
    chk("count_after_reset",  PHRASE_W'(bus_a.phrase_count), '0);
    @(posedge clk_in); #1;

    // Full phrase 1..8 with tlast on the 8th, plus one-cycle latency
    stamp_q.delete();
    push_a(128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1);
    send_seq(0, 16'h0000, 8, 1'b1, stalls, ls);
    wait_drain();
    chk("t1_phrase_num", PHRASE_W'(stamp_q.size()), PHRASE_W'(1));
    if (stamp_q.size() > 0) chk("t1_latency", PHRASE_W'(stamp_q[0]), PHRASE_W'(ls));
    chk("t1_count", PHRASE_W'(bus_a.phrase_count), PHRASE_W'(1));

    // Early close after three samples, zero and all-ones padding
    push_a(128'h0000_0000_0000_0000_0000_00A3_00A2_00A1, 1'b1);
    send_seq(0, 16'h00A0, 3, 1'b1, stalls, ls);
    push_b(128'hFFFF_FFFF_FFFF_FFFF_FFFF_00A3_00A2_00A1, 1'b1);
    send_seq(1, 16'h00A0, 3, 1'b1, stalls, ls);
    wait_drain();
    chk("t2_count_a", PHRASE_W'(bus_a.phrase_count), PHRASE_W'(2));
    chk("t2_count_b", PHRASE_W'(bus_b.phrase_count), PHRASE_W'(1));

    // Single-sample packet
    push_a(128'h0000_0000_0000_0000_0000_0000_0000_1234, 1'b1);
    send(0, 16'h1234, 1'b1, stalls, ls);
    push_b(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_1234, 1'b1);
    send(1, 16'h1234, 1'b1, stalls, ls);
    wait_drain();
    chk("t3_count_a", PHRASE_W'(bus_a.phrase_count), PHRASE_W'(3));
    chk("t3_count_b", PHRASE_W'(bus_b.phrase_count), PHRASE_W'(2));

    // Backpressure: 24 samples, first phrase held for 10 cycles
    for (int p = 0; p < 3; p++) begin
      ph = '0;
      for (int k = 0; k < 8; k++) ph[k*16 +: 16] = 16'h0100 + 16'(p*8 + k + 1);
      push_a(ph, p == 2);
    end
    bus_a.audio_chunk_tready = 1'b0;
    fork
      send_seq(0, 16'h0100, 24, 1'b1, stalls, ls);
      begin
        w = 0;
        while (!bus_a.audio_chunk_tvalid && w < 200) begin
          @(negedge clk_in);
          w++;
        end
        if (!bus_a.audio_chunk_tvalid) begin
          n_checks++;
          $display("FAIL bp_no_phrase: actual=no_tvalid required=tvalid");
        end
        held = bus_a.audio_chunk_tdata;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk_in);
          chk("bp_tready_low", PHRASE_W'(bus_a.audio_tready), '0);
          chk("bp_data_stable", bus_a.audio_chunk_tdata, held);
        end
        @(posedge clk_in); #1;
        bus_a.audio_chunk_tready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", PHRASE_W'(bus_a.phrase_count), PHRASE_W'(6));

    // Back-to-back: 64 samples, tready held high
    for (int p = 0; p < 8; p++) begin
      ph = '0;
      for (int k = 0; k < 8; k++) ph[k*16 +: 16] = 16'h2000 + 16'(p*8 + k + 1);
      push_a(ph, p == 7);
    end
    stamp_q.delete();
    send_seq(0, 16'h2000, 64, 1'b1, stalls, ls);
    wait_drain();
    chk("b2b_stalls", PHRASE_W'(stalls), '0);
    chk("b2b_phrase_num", PHRASE_W'(stamp_q.size()), PHRASE_W'(8));
    for (int i = 1; i < stamp_q.size(); i++) begin
      chk("b2b_spacing", PHRASE_W'(stamp_q[i] - stamp_q[i-1]), PHRASE_W'(8));
    end
    chk("b2b_count", PHRASE_W'(bus_a.phrase_count), PHRASE_W'(14));

    // Mid-phrase reset discards the partial accumulator
    send_seq(0, 16'h3000, 5, 1'b0, stalls, ls);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_count_cleared", PHRASE_W'(bus_a.phrase_count), '0);
    chk("rst_no_tvalid", PHRASE_W'(bus_a.audio_chunk_tvalid), '0);
    @(posedge clk_in); #1;
    push_a(128'h4008_4007_4006_4005_4004_4003_4002_4001, 1'b1);
    send_seq(0, 16'h4000, 8, 1'b1, stalls, ls);
    wait_drain();
    chk("rst_count", PHRASE_W'(bus_a.phrase_count), PHRASE_W'(1));
    chk("rst_count_b", PHRASE_W'(bus_b.phrase_count), '0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
